// File: rtl/dmem_responder_pkg.sv
// Shared constants, FSM state encoding and helpers for the rooth data-memory responder.
package dmem_responder_pkg;

  localparam int          CPU_WIDTH       = 32;
  localparam logic [31:0] DMEM_BASE_ADDR  = 32'h1000_0000;
  localparam int          DMEM_DEPTH_LOG2 = 12;

  typedef enum logic [0:0] {
    DMEM_ST_IDLE  = 1'b0,
    DMEM_ST_ARMED = 1'b1
  } dmem_state_e;

  // Saturating increment: the counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    if (cnt == 32'hFFFF_FFFF) begin
      return cnt;
    end else begin
      return cnt + 32'd1;
    end
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-memory bus plus loader write port between the rooth core/loader and the responder.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic                 mem_req;
  logic                 mem_wr_en;
  logic [CPU_WIDTH-1:0] mem_addr;
  logic [CPU_WIDTH-1:0] mem_wdata;
  logic [CPU_WIDTH-1:0] mem_rdata;
  logic                 mem_err;
  logic                 ld_we;
  logic [CPU_WIDTH-1:0] ld_addr;
  logic [CPU_WIDTH-1:0] ld_data;
  logic                 ld_busy;

  modport master (
    output mem_req, mem_wr_en, mem_addr, mem_wdata, ld_we, ld_addr, ld_data,
    input  mem_rdata, mem_err, ld_busy
  );

  modport slave (
    input  mem_req, mem_wr_en, mem_addr, mem_wdata, ld_we, ld_addr, ld_data,
    output mem_rdata, mem_err, ld_busy
  );

endinterface

// File: rtl/dmem_responder_ram_sp.sv
// Single-port synchronous RAM, write-first, shaped for block-RAM inference.
module dmem_ram_sp #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];
  logic [DW-1:0] rdata_r;

  // Array write and registered read; a write also forwards its data to the output.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[addr] <= wdata;
        rdata_r     <= wdata;
      end else begin
        rdata_r     <= mem_r[addr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: window decode, core/loader arbitration onto one RAM port,
// read-then-write protocol check and saturating access counters.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DMEM_BASE_ADDR,
  parameter int          DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_responder_if.slave    bus,
  output logic               proto_err_o,
  output logic [31:0]        rd_cnt_o,
  output logic [31:0]        wr_cnt_o
);

  localparam int HI = DEPTH_LOG2 + 2;

  logic                  core_in_range_s;
  logic                  ld_in_range_s;
  logic [DEPTH_LOG2-1:0] core_idx_s;
  logic [DEPTH_LOG2-1:0] ld_idx_s;
  logic                  core_rd_s;
  logic                  core_wr_s;

  logic                  ram_en_s;
  logic                  ram_we_s;
  logic [DEPTH_LOG2-1:0] ram_idx_s;
  logic [CPU_WIDTH-1:0]  ram_wdata_s;
  logic [CPU_WIDTH-1:0]  ram_rdata_s;

  logic                  rd_fire_r;
  logic                  rd_oor_r;
  logic [CPU_WIDTH-1:0]  rdata_hold_r;
  logic [CPU_WIDTH-1:0]  rdata_s;
  logic                  mem_err_r;
  logic                  proto_err_r;
  logic [31:0]           rd_cnt_r;
  logic [31:0]           wr_cnt_r;

  dmem_state_e           state_r;
  dmem_state_e           state_nxt_s;
  logic [DEPTH_LOG2-1:0] armed_idx_r;
  logic [DEPTH_LOG2-1:0] armed_idx_nxt_s;
  logic                  proto_set_s;

  logic                  unused_s;

  assign core_in_range_s = (bus.mem_addr[CPU_WIDTH-1:HI] == BASE_ADDR[CPU_WIDTH-1:HI]);
  assign ld_in_range_s   = (bus.ld_addr[CPU_WIDTH-1:HI]  == BASE_ADDR[CPU_WIDTH-1:HI]);
  assign core_idx_s      = bus.mem_addr[HI-1:2];
  assign ld_idx_s        = bus.ld_addr[HI-1:2];
  assign core_rd_s       = bus.mem_req & ~bus.mem_wr_en;
  assign core_wr_s       = bus.mem_req &  bus.mem_wr_en;
  assign unused_s        = ^{bus.mem_addr[1:0], bus.ld_addr[1:0]};

  // RAM port arbitration: the core always owns the port while it requests; no write under reset.
  always_comb begin
    ram_en_s    = 1'b0;
    ram_we_s    = 1'b0;
    ram_idx_s   = core_idx_s;
    ram_wdata_s = bus.mem_wdata;
    if (!rst_n) begin
      ram_en_s = 1'b0;
    end else if (bus.mem_req) begin
      ram_en_s = core_in_range_s;
      ram_we_s = core_in_range_s & bus.mem_wr_en;
    end else if (bus.ld_we && ld_in_range_s) begin
      ram_en_s    = 1'b1;
      ram_we_s    = 1'b1;
      ram_idx_s   = ld_idx_s;
      ram_wdata_s = bus.ld_data;
    end else begin
      ram_en_s = 1'b0;
    end
  end

  dmem_ram_sp #(
    .AW (DEPTH_LOG2),
    .DW (CPU_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en_s),
    .we    (ram_we_s),
    .addr  (ram_idx_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // RAM output also moves on writes, so the visible word is held separately between reads.
  always_comb begin
    if (rd_fire_r) begin
      rdata_s = ram_rdata_s;
    end else if (rd_oor_r) begin
      rdata_s = {CPU_WIDTH{1'b0}};
    end else begin
      rdata_s = rdata_hold_r;
    end
  end

  // Protocol FSM: a write must follow a read of the same word index.
  always_comb begin
    state_nxt_s     = state_r;
    armed_idx_nxt_s = armed_idx_r;
    proto_set_s     = 1'b0;
    case (state_r)
      DMEM_ST_IDLE: begin
        if (core_wr_s) begin
          proto_set_s = 1'b1;
        end else if (core_rd_s) begin
          state_nxt_s     = DMEM_ST_ARMED;
          armed_idx_nxt_s = core_idx_s;
        end else begin
          state_nxt_s = DMEM_ST_IDLE;
        end
      end
      DMEM_ST_ARMED: begin
        if (core_wr_s) begin
          state_nxt_s = DMEM_ST_IDLE;
          proto_set_s = (core_idx_s != armed_idx_r);
        end else if (core_rd_s) begin
          state_nxt_s     = DMEM_ST_ARMED;
          armed_idx_nxt_s = core_idx_s;
        end else begin
          state_nxt_s = DMEM_ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = DMEM_ST_IDLE;
      end
    endcase
  end

  // State, status flags, read-data tracking and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= DMEM_ST_IDLE;
      armed_idx_r  <= {DEPTH_LOG2{1'b0}};
      rd_fire_r    <= 1'b0;
      rd_oor_r     <= 1'b0;
      rdata_hold_r <= {CPU_WIDTH{1'b0}};
      mem_err_r    <= 1'b0;
      proto_err_r  <= 1'b0;
      rd_cnt_r     <= 32'd0;
      wr_cnt_r     <= 32'd0;
    end else begin
      state_r      <= state_nxt_s;
      armed_idx_r  <= armed_idx_nxt_s;
      rd_fire_r    <= core_rd_s & core_in_range_s;
      rd_oor_r     <= core_rd_s & ~core_in_range_s;
      rdata_hold_r <= rdata_s;
      mem_err_r    <= bus.mem_req & ~core_in_range_s;
      proto_err_r  <= proto_err_r | proto_set_s;
      if (core_rd_s && core_in_range_s) begin
        rd_cnt_r <= sat_inc(rd_cnt_r);
      end
      if (core_wr_s && core_in_range_s) begin
        wr_cnt_r <= sat_inc(wr_cnt_r);
      end
    end
  end

  assign bus.mem_rdata = rdata_s;
  assign bus.mem_err   = mem_err_r;
  assign bus.ld_busy   = bus.ld_we & bus.mem_req;
  assign proto_err_o   = proto_err_r;
  assign rd_cnt_o      = rd_cnt_r;
  assign wr_cnt_o      = wr_cnt_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: loader download, load/store sequences, range, protocol, reset.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        proto_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  int          n_tests;
  int          n_fail;

  dmem_responder_if bus ();

  dmem_responder u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .proto_err_o (proto_err),
    .rd_cnt_o    (rd_cnt),
    .wr_cnt_o    (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One core access sampled on the next edge; the bus is released afterwards.
  task automatic core_op(input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.mem_req   = 1'b1;
    bus.mem_wr_en = wr;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    step();
    bus.mem_req   = 1'b0;
    bus.mem_wr_en = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    bus.ld_we   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    step();
    bus.ld_we   = 1'b0;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.ld_we     = 1'b0;
    bus.ld_addr   = 32'h0;
    bus.ld_data   = 32'h0;
    step();
    step();
    check_eq("rst_rdata", bus.mem_rdata, 32'h0);
    check_eq("rst_err",   {31'h0, bus.mem_err}, 32'h0);
    check_eq("rst_proto", {31'h0, proto_err}, 32'h0);
    check_eq("rst_rdcnt", rd_cnt, 32'h0);
    check_eq("rst_wrcnt", wr_cnt, 32'h0);
    check_eq("rst_busy",  {31'h0, bus.ld_busy}, 32'h0);
    rst_n = 1'b1;

    load_word(32'h1000_0010, 32'hDEAD_BEEF);
    load_word(32'h1000_0004, 32'h1122_3344);
    load_word(32'h1000_0000, 32'hA5A5_0000);
    load_word(32'h1000_0020, 32'h0000_0055);

    // Store word via loader, then core load
    core_op(1'b0, 32'h1000_0010, 32'h0);
    check_eq("sw_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
    check_eq("sw_err",   {31'h0, bus.mem_err}, 32'h0);
    check_eq("sw_rdcnt", rd_cnt, 32'd1);
    step();

    // Store-byte read-modify-write, then read-after-write
    core_op(1'b0, 32'h1000_0004, 32'h0);
    check_eq("rmw_rd1", bus.mem_rdata, 32'h1122_3344);
    core_op(1'b1, 32'h1000_0004, 32'h1122_33AA);
    check_eq("rmw_hold",  bus.mem_rdata, 32'h1122_3344);
    check_eq("rmw_wrcnt", wr_cnt, 32'd1);
    check_eq("rmw_proto", {31'h0, proto_err}, 32'h0);
    core_op(1'b0, 32'h1000_0004, 32'h0);
    check_eq("rmw_rd2",   bus.mem_rdata, 32'h1122_33AA);
    check_eq("rmw_rdcnt", rd_cnt, 32'd3);
    step();

    // Out of range read and write
    core_op(1'b0, 32'h2000_0000, 32'h0);
    check_eq("oor_rdata", bus.mem_rdata, 32'h0);
    check_eq("oor_err",   {31'h0, bus.mem_err}, 32'h1);
    check_eq("oor_rdcnt", rd_cnt, 32'd3);
    step();
    check_eq("oor_errpulse", {31'h0, bus.mem_err}, 32'h0);
    core_op(1'b0, 32'h2000_0000, 32'h0);
    core_op(1'b1, 32'h2000_0000, 32'hFFFF_FFFF);
    check_eq("oorw_err",   {31'h0, bus.mem_err}, 32'h1);
    check_eq("oorw_wrcnt", wr_cnt, 32'd1);
    check_eq("oorw_proto", {31'h0, proto_err}, 32'h0);
    core_op(1'b0, 32'h1000_0000, 32'h0);
    check_eq("oorw_mem",   bus.mem_rdata, 32'hA5A5_0000);
    check_eq("oorw_rdcnt", rd_cnt, 32'd4);
    step();

    // Write with no preceding read
    core_op(1'b1, 32'h1000_0008, 32'h0BAD_0008);
    check_eq("proto_set",   {31'h0, proto_err}, 32'h1);
    check_eq("proto_wrcnt", wr_cnt, 32'd2);
    step();
    step();
    step();
    check_eq("proto_sticky", {31'h0, proto_err}, 32'h1);

    // Loader collides with a core read, then retries while the core is idle
    bus.mem_req   = 1'b1;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = 32'h1000_0010;
    bus.ld_we     = 1'b1;
    bus.ld_addr   = 32'h1000_0020;
    bus.ld_data   = 32'hCAFE_F00D;
    #1;
    check_eq("col_busy", {31'h0, bus.ld_busy}, 32'h1);
    step();
    bus.mem_req = 1'b0;
    bus.ld_we   = 1'b0;
    step();
    core_op(1'b0, 32'h1000_0020, 32'h0);
    check_eq("col_kept", bus.mem_rdata, 32'h0000_0055);
    bus.ld_we = 1'b1;
    #1;
    check_eq("retry_busy", {31'h0, bus.ld_busy}, 32'h0);
    step();
    bus.ld_we = 1'b0;
    core_op(1'b0, 32'h1000_0020, 32'h0);
    check_eq("retry_data",  bus.mem_rdata, 32'hCAFE_F00D);
    check_eq("retry_rdcnt", rd_cnt, 32'd7);

    // Reset lands on the write cycle of a store to the armed word
    rst_n = 1'b0;
    core_op(1'b1, 32'h1000_0020, 32'h1234_5678);
    check_eq("rstw_rdata", bus.mem_rdata, 32'h0);
    check_eq("rstw_err",   {31'h0, bus.mem_err}, 32'h0);
    check_eq("rstw_proto", {31'h0, proto_err}, 32'h0);
    check_eq("rstw_rdcnt", rd_cnt, 32'h0);
    check_eq("rstw_wrcnt", wr_cnt, 32'h0);
    rst_n = 1'b1;
    // Same word index, out of the window: only an idle FSM flags it
    core_op(1'b1, 32'h2000_0020, 32'h0);
    check_eq("rstw_idle", {31'h0, proto_err}, 32'h1);
    check_eq("rstw_oor",  {31'h0, bus.mem_err}, 32'h1);
    step();
    core_op(1'b0, 32'h1000_0020, 32'h0);
    check_eq("rstw_mem",   bus.mem_rdata, 32'hCAFE_F00D);
    check_eq("rstw_rdcnt1", rd_cnt, 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
